// File: rtl/xif_coproc_ctrl_pkg.sv
// Shared types and constants for the XIF coprocessor controller.
// Included first so every other file can import xif_coproc_pkg::*.
package xif_coproc_pkg;

    localparam int XIF_XLEN  = 32;
    localparam int XIF_ID_W  = 4;
    localparam int XIF_RFW_W = 32;
    localparam int XIF_DEPTH = 4;

    typedef enum logic [1:0] {
        FREE,
        ISSUED,
        COMMITTED,
        KILLED
    } id_state_e;

    typedef struct packed {
        logic [XIF_ID_W-1:0]  id;
        logic [XIF_RFW_W-1:0] data;
        logic [4:0]           rd;
        logic                 we;
        logic                 exc;
        logic [5:0]           exccode;
    } res_entry_t;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [4:0] F5_FCMP   = 5'b10100;
    localparam logic [4:0] F5_FMV_X  = 5'b11100;
    localparam logic [4:0] F5_FCVT_W = 5'b11000;

endpackage

// File: rtl/xif_coproc_ctrl_if.sv
// Issue/commit/result channels plus the FPU op and result links.
// slave is the coprocessor controller, master drives it.
interface xif_coproc_ctrl_if
    import xif_coproc_pkg::*;
#(
    parameter int XLEN        = XIF_XLEN,
    parameter int X_ID_WIDTH  = XIF_ID_W,
    parameter int X_RFW_WIDTH = XIF_RFW_W
) ();

    logic                   issue_valid;
    logic                   issue_ready;
    logic [XLEN-1:0]        issue_instr;
    logic [X_ID_WIDTH-1:0]  issue_id;
    logic                   issue_accept;
    logic                   issue_writeback;

    logic                   commit_valid;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   commit_kill;

    logic                   op_valid;
    logic                   op_ready;
    logic [XLEN-1:0]        op_instr;
    logic [X_ID_WIDTH-1:0]  op_id;

    logic                   fpu_res_valid;
    logic [X_ID_WIDTH-1:0]  fpu_res_id;
    logic [X_RFW_WIDTH-1:0] fpu_res_data;
    logic [4:0]             fpu_res_rd;
    logic                   fpu_res_exc;
    logic [5:0]             fpu_res_exccode;

    logic                   result_valid;
    logic                   result_ready;
    logic [X_ID_WIDTH-1:0]  result_id;
    logic [X_RFW_WIDTH-1:0] result_data;
    logic [4:0]             result_rd;
    logic                   result_we;
    logic                   result_exc;
    logic [5:0]             result_exccode;

    modport slave (
        input  issue_valid, issue_instr, issue_id,
        output issue_ready, issue_accept, issue_writeback,
        input  commit_valid, commit_id, commit_kill,
        output op_valid, op_instr, op_id,
        input  op_ready,
        input  fpu_res_valid, fpu_res_id, fpu_res_data,
        input  fpu_res_rd, fpu_res_exc, fpu_res_exccode,
        output result_valid, result_id, result_data,
        output result_rd, result_we, result_exc, result_exccode,
        input  result_ready
    );

    modport master (
        output issue_valid, issue_instr, issue_id,
        input  issue_ready, issue_accept, issue_writeback,
        output commit_valid, commit_id, commit_kill,
        input  op_valid, op_instr, op_id,
        output op_ready,
        output fpu_res_valid, fpu_res_id, fpu_res_data,
        output fpu_res_rd, fpu_res_exc, fpu_res_exccode,
        input  result_valid, result_id, result_data,
        input  result_rd, result_we, result_exc, result_exccode,
        output result_ready
    );

endinterface

// File: rtl/xif_coproc_ctrl_fifo.sv
// Synchronous circular FIFO for FPU result entries; head is read
// straight from storage so it is visible the cycle after the push.
module xif_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d  = push_i ? nxt(wr_q) : wr_q;
        rd_d  = pop_i ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/xif_coproc_ctrl.sv
// XIF coprocessor controller: decode, per-ID commit tracking and
// completion-order retire of FPU results back to the CPU.
module xif_coproc_ctrl
    import xif_coproc_pkg::*;
#(
    parameter int DEPTH = XIF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    xif_coproc_ctrl_if.slave bus
);
    localparam int NID = 2 ** XIF_ID_W;
    localparam int CW  = $clog2(DEPTH + 1);

    id_state_e      state_q [NID];
    id_state_e      state_d [NID];
    logic [NID-1:0] wb_q, wb_d;
    logic [CW-1:0]  inflight_q, inflight_d;

    logic [6:0]    opc;
    logic [4:0]    f5;
    logic          dec_acc, dec_wb;
    logic          hs, iss, pop, rv;
    res_entry_t    push_e, head;
    id_state_e     head_st;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;
    logic          unused_fifo;

    always_comb begin
        opc     = bus.issue_instr[6:0];
        f5      = bus.issue_instr[31:27];
        dec_acc = opc inside {OPC_OP_FP, OPC_FMADD, OPC_FMSUB,
                              OPC_FNMSUB, OPC_FNMADD};
        dec_wb  = dec_acc &
                  (f5 inside {F5_FCMP, F5_FMV_X, F5_FCVT_W});
    end

    assign bus.issue_ready = !rst & bus.op_ready &
                             (inflight_q < CW'(DEPTH)) &
                             (state_q[bus.issue_id] == FREE);
    assign hs  = bus.issue_valid & bus.issue_ready;
    assign iss = hs & dec_acc;

    assign bus.issue_accept    = iss;
    assign bus.issue_writeback = hs & dec_wb;
    assign bus.op_valid        = iss;
    assign bus.op_instr        = bus.issue_instr;
    assign bus.op_id           = bus.issue_id;

    always_comb begin
        push_e         = '0;
        push_e.id      = bus.fpu_res_id;
        push_e.data    = bus.fpu_res_data;
        push_e.rd      = bus.fpu_res_rd;
        push_e.we      = wb_q[bus.fpu_res_id];
        push_e.exc     = bus.fpu_res_exc;
        push_e.exccode = bus.fpu_res_exccode;
    end

    xif_result_fifo #(
        .W     ($bits(res_entry_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.fpu_res_valid),
        .pop_i   (pop),
        .data_i  (push_e),
        .data_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Credit tracking already rules out overflow; count/full are spare.
    assign unused_fifo = ^{fifo_cnt, fifo_full};

    // Head waits while ISSUED, drops silently when KILLED.
    assign head_st = state_q[head.id];
    assign rv  = !fifo_empty & (head_st == COMMITTED);
    assign pop = !fifo_empty &
                 ((head_st == KILLED) | (rv & bus.result_ready));

    assign bus.result_valid   = rv;
    assign bus.result_id      = rv ? head.id : '0;
    assign bus.result_data    = rv ? head.data : '0;
    assign bus.result_rd      = rv ? head.rd : '0;
    assign bus.result_we      = rv & head.we;
    assign bus.result_exc     = rv & head.exc;
    assign bus.result_exccode = rv ? head.exccode : '0;

    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        inflight_d = inflight_q + CW'(iss) - CW'(pop);
        if (pop) state_d[head.id] = FREE;
        if (bus.commit_valid && state_q[bus.commit_id] == ISSUED)
            state_d[bus.commit_id] = bus.commit_kill ? KILLED : COMMITTED;
        if (iss) begin
            state_d[bus.issue_id] = ISSUED;
            wb_d[bus.issue_id]    = dec_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NID; i++) state_q[i] <= FREE;
            wb_q       <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_xif_coproc_ctrl.sv
// Random and directed stimulus for xif_coproc_ctrl against a
// transaction-level model of IDs, commits and the result queue.
module tb_xif_coproc_ctrl;

    localparam int NID = 16;
    localparam logic [31:0] FADD = 32'h00A574D3;
    localparam logic [31:0] FEQ  = {7'b1010000, 5'd2, 5'd1, 3'b010,
                                    5'd5, 7'b1010011};
    localparam logic [31:0] IADD = 32'h00B50533;

    typedef enum int {M_FREE, M_ISS, M_COM, M_KIL} mst_e;
    typedef struct {
        int          id;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          we;
        bit          exc;
        logic [5:0]  code;
    } mres_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xif_coproc_ctrl_if bus ();
    xif_coproc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    mst_e  mst [NID];
    bit    mwb [NID];
    mres_t mq [$];
    int    pend [$];

    logic [6:0] opcs [8] = '{7'h53, 7'h43, 7'h47, 7'h4B,
                             7'h4F, 7'h07, 7'h27, 7'h33};
    logic [4:0] f5s  [4] = '{5'b10100, 5'b11100, 5'b11000, 5'b00000};

    logic        s_iv, s_cv, s_ck, s_opr, s_fv, s_fexc, s_rr;
    logic [31:0] s_instr, s_fd;
    logic [3:0]  s_iid, s_cid, s_fid;
    logic [4:0]  s_frd;
    logic [5:0]  s_fcode;

    bit          o_rdy, o_rv, o_we;
    logic [31:0] o_data;
    logic [3:0]  o_id;
    logic [4:0]  o_rd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_acc(input logic [31:0] ins);
        logic [6:0] o;
        o = ins[6:0];
        return o == 7'h53 || o == 7'h43 || o == 7'h47 ||
               o == 7'h4B || o == 7'h4F;
    endfunction

    function automatic bit ref_wb(input logic [31:0] ins);
        logic [4:0] f;
        f = ins[31:27];
        return ref_acc(ins) &&
               (f == 5'b10100 || f == 5'b11100 || f == 5'b11000);
    endfunction

    function automatic int nbusy();
        int n = 0;
        foreach (mst[i]) if (mst[i] != M_FREE) n++;
        return n;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        r[6:0] = opcs[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) r[31:27] = f5s[$urandom_range(0, 3)];
        return r;
    endfunction

    task automatic model_clear();
        foreach (mst[i]) begin
            mst[i] = M_FREE;
            mwb[i] = 1'b0;
        end
        mq.delete();
        pend.delete();
    endtask

    task automatic idle();
        s_iv = 0; s_instr = '0; s_iid = '0;
        s_cv = 0; s_cid = '0; s_ck = 0; s_opr = 1;
        s_fv = 0; s_fid = '0; s_fd = '0; s_frd = '0;
        s_fexc = 0; s_fcode = '0; s_rr = 1;
    endtask

    task automatic drive();
        bus.issue_valid     = s_iv;
        bus.issue_instr     = s_instr;
        bus.issue_id        = s_iid;
        bus.commit_valid    = s_cv;
        bus.commit_id       = s_cid;
        bus.commit_kill     = s_ck;
        bus.op_ready        = s_opr;
        bus.fpu_res_valid   = s_fv;
        bus.fpu_res_id      = s_fid;
        bus.fpu_res_data    = s_fd;
        bus.fpu_res_rd      = s_frd;
        bus.fpu_res_exc     = s_fexc;
        bus.fpu_res_exccode = s_fcode;
        bus.result_ready    = s_rr;
    endtask

    // One clock: drive, check against the model, then advance the model.
    task automatic step();
        bit    rdy, acc, wb, hs, rv;
        int    k;
        mres_t h, e;
        @(negedge clk);
        drive();
        #1;
        rdy = s_opr && nbusy() < 4 && mst[s_iid] == M_FREE;
        acc = ref_acc(s_instr);
        wb  = ref_wb(s_instr);
        hs  = s_iv && rdy;
        chk("issue_ready", bus.issue_ready, rdy);
        chk("issue_accept", bus.issue_accept, hs && acc);
        chk("issue_writeback", bus.issue_writeback, hs && wb);
        chk("op_valid", bus.op_valid, hs && acc);
        if (hs && acc) begin
            chk("op_id", bus.op_id, s_iid);
            chk("op_instr", bus.op_instr, s_instr);
        end
        rv = (mq.size() > 0) && (mst[mq[0].id] == M_COM);
        chk("result_valid", bus.result_valid, rv);
        if (rv) begin
            h = mq[0];
            chk("result_id", bus.result_id, h.id);
            chk("result_data", bus.result_data, h.data);
            chk("result_rd", bus.result_rd, h.rd);
            chk("result_we", bus.result_we, h.we);
            chk("result_exc", bus.result_exc, h.exc);
            chk("result_exccode", bus.result_exccode, h.code);
        end
        o_rdy = bus.issue_ready; o_rv = bus.result_valid;
        o_data = bus.result_data; o_id = bus.result_id;
        o_rd = bus.result_rd; o_we = bus.result_we;
        if (mq.size() > 0 && (mst[mq[0].id] == M_KIL || (rv && s_rr))) begin
            mst[mq[0].id] = M_FREE;
            void'(mq.pop_front());
        end
        if (s_cv && mst[s_cid] == M_ISS) mst[s_cid] = s_ck ? M_KIL : M_COM;
        if (hs && acc) begin
            mst[s_iid] = M_ISS;
            mwb[s_iid] = wb;
            pend.push_back(int'(s_iid));
        end
        if (s_fv) begin
            e = '{id: int'(s_fid), data: s_fd, rd: s_frd,
                  we: mwb[s_fid], exc: s_fexc, code: s_fcode};
            mq.push_back(e);
            k = -1;
            foreach (pend[i]) if (pend[i] == int'(s_fid)) k = i;
            if (k >= 0) pend.delete(k);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(); s_iv = 1; s_instr = FADD; drive();
        #1;
        chk("rst_issue_ready", bus.issue_ready, 0);
        chk("rst_issue_accept", bus.issue_accept, 0);
        chk("rst_op_valid", bus.op_valid, 0);
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        idle(); drive();
        #1;
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_result_data", bus.result_data, 0);
        chk("rst_result_id", bus.result_id, 0);
    endtask

    task automatic rnd_cycle(input bit drain);
        int iss [$];
        idle();
        foreach (mst[i]) if (mst[i] == M_ISS) iss.push_back(i);
        if (!drain) begin
            s_iv    = 1'($urandom_range(0, 1));
            s_instr = rnd_instr();
            s_iid   = 4'($urandom);
            s_opr   = ($urandom_range(0, 7) != 0);
            s_rr    = ($urandom_range(0, 3) != 0);
        end
        if (drain || $urandom_range(0, 2) == 0) begin
            s_cv  = 1;
            s_cid = (iss.size() > 0 && $urandom_range(0, 3) != 0)
                    ? 4'(iss[$urandom_range(0, iss.size() - 1)])
                    : 4'($urandom);
            s_ck  = ($urandom_range(0, 3) == 0);
        end
        if (pend.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
            s_fv    = 1;
            s_fid   = 4'(pend[$urandom_range(0, pend.size() - 1)]);
            s_fd    = $urandom;
            s_frd   = 5'($urandom);
            s_fexc  = 1'($urandom_range(0, 1));
            s_fcode = 6'($urandom);
        end
        step();
    endtask

    initial begin
        int k;
        logic [31:0] d0;
        logic [3:0]  i0;
        model_clear();
        idle(); drive();
        repeat (2) @(posedge clk);
        do_reset();

        idle(); s_iv = 1; s_instr = FADD; s_iid = 3; step();
        idle(); s_cv = 1; s_cid = 3; step();
        idle(); s_fv = 1; s_fid = 3; s_fd = 32'h3F800000; s_frd = 5'd9; step();
        idle(); step();
        chk("fadd_res_valid", o_rv, 1);
        chk("fadd_res_data", o_data, 32'h3F800000);
        chk("fadd_res_we", o_we, 0);

        idle(); s_iv = 1; s_instr = FEQ; s_iid = 5; step();
        idle(); s_cv = 1; s_cid = 5; step();
        idle(); s_fv = 1; s_fid = 5; s_fd = 32'd1; s_frd = 5'd5; step();
        idle(); step();
        chk("feq_res_we", o_we, 1);
        chk("feq_res_rd", o_rd, 5);

        idle(); s_iv = 1; s_instr = IADD; s_iid = 7; step();
        idle(); s_iid = 7; step();
        chk("iadd_id_free", o_rdy, 1);

        idle(); s_iv = 1; s_instr = FADD; s_iid = 2; step();
        idle(); s_cv = 1; s_cid = 2; s_ck = 1; step();
        idle(); s_fv = 1; s_fid = 2; s_fd = 32'hDEAD; step();
        k = 0;
        do begin
            idle(); s_iid = 2; step(); k++;
        end while (!o_rdy && k < 8);
        chk("kill_reuse_cycles", k, 2);

        for (int i = 0; i < 4; i++) begin
            idle(); s_iv = 1; s_instr = FADD; s_iid = 4'(i); step();
        end
        idle(); s_iv = 1; s_instr = FADD; s_iid = 4; step();
        chk("full_ready", o_rdy, 0);
        idle(); s_cv = 1; s_cid = 0; step();
        idle(); s_fv = 1; s_fid = 0; s_fd = 32'h40000000; step();
        idle(); step();
        idle(); s_iid = 4; step();
        chk("credit_ready", o_rdy, 1);

        idle(); s_fv = 1; s_fid = 1; s_fd = 32'h12345678; s_frd = 5'd7; step();
        idle(); step();
        chk("precommit_rv", o_rv, 0);
        idle(); s_cv = 1; s_cid = 1; step();
        idle(); s_rr = 0; step();
        chk("postcommit_rv", o_rv, 1);
        d0 = o_data; i0 = o_id;
        for (int i = 0; i < 2; i++) begin
            idle(); s_rr = 0; step();
            chk("hold_valid", o_rv, 1);
            chk("hold_data", o_data, d0);
            chk("hold_id", o_id, i0);
        end
        do_reset();
        for (int i = 0; i < NID; i++) begin
            idle(); s_iid = 4'(i); step();
            chk("post_rst_free", o_rdy, 1);
        end

        for (int c = 0; c < 3000; c++) rnd_cycle(1'b0);
        for (int c = 0; c < 400 && (nbusy() > 0 || mq.size() > 0); c++)
            rnd_cycle(1'b1);
        for (int i = 0; i < NID; i++) begin
            idle(); s_iid = 4'(i); step();
            chk("drain_free", o_rdy, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xif_coproc_ctrl.md
Name: xif_coproc_ctrl

Overview:
- Coprocessor-side controller for the CORE-V-XIF issue, commit and result channels; the rvfpm end of the link the CPU drives.
- Decodes offloaded instructions and drives accept/writeback.
- Forwards accepted instructions to the FPU core and tracks each ID through commit or kill.
- Buffers FPU results and returns committed results to the CPU with valid/ready; killed results are discarded.

Parameters:
- XLEN, 32, integer register width.
- X_ID_WIDTH, 4, instruction ID width; the ID table has 2**X_ID_WIDTH entries.
- X_RFW_WIDTH, 32, result data width.
- DEPTH, 4, result FIFO depth and also the maximum number of accepted-but-unretired instructions.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  issue request valid
- issue_ready  out  1  issue request ready
- issue_instr  in  32  offloaded instruction
- issue_id  in  X_ID_WIDTH  instruction ID
- issue_accept  out  1  issue_resp.accept
- issue_writeback  out  1  issue_resp.writeback
- commit_valid  in  1  commit valid
- commit_id  in  X_ID_WIDTH  commit.id
- commit_kill  in  1  commit.commit_kill
- op_valid  out  1  instruction to FPU valid
- op_ready  in  1  FPU can take an instruction
- op_instr  out  32  instruction to FPU
- op_id  out  X_ID_WIDTH  ID to FPU
- fpu_res_valid  in  1  FPU result valid (always accepted)
- fpu_res_id  in  X_ID_WIDTH  result ID
- fpu_res_data  in  X_RFW_WIDTH  result data
- fpu_res_rd  in  5  destination register
- fpu_res_exc  in  1  exception flag
- fpu_res_exccode  in  6  exception code
- result_valid  out  1  result to CPU valid
- result_ready  in  1  CPU accepts result
- result_id  out  X_ID_WIDTH  result.id
- result_data  out  X_RFW_WIDTH  result.data
- result_rd  out  5  result.rd
- result_we  out  1  result.we
- result_exc  out  1  result.exc
- result_exccode  out  6  result.exccode

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all ID states return to FREE, FIFO empties, inflight=0. result_valid=0, op_valid=0, all result_* fields=0. issue_ready/issue_accept/issue_writeback are combinational and are 0 while rst=1.
- Decode (combinational on issue_instr):
  - accept=1 iff opcode[6:0] is 1010011 (OP-FP) or in {1000011, 1000111, 1001011, 1001111} (fused multiply-add family).
  - LOAD-FP and STORE-FP are rejected; they are handled by the mem channel block.
  - writeback=accept AND funct7[6:2] in {10100 FCMP, 11100 FMV.X.W/FCLASS, 11000 FCVT.W[U]}.
- issue_ready = !rst & op_ready & (inflight<DEPTH) & (state[issue_id]==FREE).
- Issue handshake = issue_valid & issue_ready. issue_accept and issue_writeback are meaningful only during the handshake and are driven 0 whenever issue_valid=0.
- On a handshake with accept=1: op_valid=1 in the same cycle (combinational pass-through); state[id]<=ISSUED; wb flag stored per ID; inflight++.
- On a handshake with accept=0: no state change and op_valid=0.
- ID state machine, per ID:
  - FREE -> ISSUED on accepted issue.
  - ISSUED -> COMMITTED on commit_valid with kill=0; ISSUED -> KILLED on commit_valid with kill=1.
  - COMMITTED/KILLED -> FREE on retire.
  - Commit for an ID in FREE, COMMITTED or KILLED is ignored.
  - Commit and accepted issue on the same ID in the same cycle cannot occur, because issue requires FREE.
- FPU results: every fpu_res_valid pushes {id, data, rd, exc, exccode, we=wb[id]} into the FIFO. FIFO overflow is impossible by the inflight credit.
- Retire logic at the FIFO head (registered outputs, head visible the cycle after push):
  - COMMITTED: result_valid=1. The fields must hold stable while result_valid=1 & result_ready=0. On handshake: pop, state<=FREE, inflight--.
  - KILLED: pop silently in one cycle, result_valid=0, state<=FREE, inflight--.
  - ISSUED: stall with result_valid=0 until commit arrives.
- Results return in FPU completion order, not issue order.
- Simultaneous events:
  - A retire and an accepted issue in the same cycle leave inflight unchanged.
  - A commit for the head ID in the same cycle the head is examined takes effect next cycle.
  - A push and a pop in the same cycle keep the FIFO count unchanged.
- Mid-operation reset: all in-flight IDs are dropped and no result is emitted.

Decomposition:
- Package xif_coproc_pkg holds:
  - id_state_e {FREE, ISSUED, COMMITTED, KILLED};
  - the result entry struct;
  - opcode constants OPC_OP_FP and OPC_FMADD..OPC_FNMADD;
  - funct5 constants for the writeback class.
- Sub-module: xif_result_fifo, a parameterised synchronous FIFO with count, full and empty outputs.

Test Plan:
- Issue 0x00A574D3 (fadd.s, opcode 1010011) with id=3 and op_ready=1 -> same cycle accept=1, writeback=0, op_valid=1, op_id=3. Commit id=3 kill=0, then FPU result data=0x3F800000 -> result_valid with id=3, data=0x3F800000, we=0.
- Issue feq.s (funct7=1010000) with id=5, commit, result data=1 -> accept=1, writeback=1, result_we=1, result_rd matches.
- Issue an instruction with opcode 0110011 (integer ADD) -> accept=0, op_valid=0, no state change, inflight=0.
- Issue id=2, commit with kill=1, FPU returns result id=2 -> no result_valid; id=2 reusable 2 cycles later (issue_ready=1).
- Issue ids 0..3 (DEPTH=4) with none retired -> issue_ready=0 for id 4. Retire one -> issue_ready=1.
- Result queued for id=1 before commit -> result_valid stays 0. Commit arrives -> result_valid=1 next cycle. Hold result_ready=0 for 3 cycles -> fields stable. Assert rst mid-hold -> result_valid=0 next cycle and all IDs FREE.
